// File: rtl/cpu_axi4lite_bridge.sv
// cpu_axi4lite_bridge: CPU req/gnt/rvalid data port to single-outstanding AXI4-lite master
module cpu_axi4lite_bridge #(
  parameter int          DW        = 32,
  parameter int          AW        = 32,
  parameter int          SW        = 4,
  parameter logic [31:0] BASE_ADDR = 32'h8000,
  parameter logic [31:0] WIN_SIZE  = 32'h00F8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          data_req,
  output logic          data_gnt,
  output logic          data_rvalid,
  input  logic          data_we,
  input  logic [SW-1:0] data_be,
  input  logic [AW-1:0] data_addr,
  input  logic [DW-1:0] data_wdata,
  output logic [DW-1:0] data_rdata,
  output logic          data_err,
  output logic [AW-1:0] awaddr,
  output logic          awvalid,
  input  logic          awready,
  output logic [DW-1:0] wdata,
  output logic [SW-1:0] wstrb,
  output logic          wvalid,
  input  logic          wready,
  input  logic          bvalid,
  input  logic [1:0]    bresp,
  output logic          bready,
  output logic [AW-1:0] araddr,
  output logic          arvalid,
  input  logic          arready,
  input  logic          rvalid,
  input  logic [1:0]    rresp,
  input  logic [DW-1:0] rdata,
  output logic          rready
);
  typedef enum logic [2:0] {IDLE, WADDR, WRESP, RADDR, RDATA, RESP} state_t;
  localparam logic [AW-1:0] LO = AW'(BASE_ADDR);
  localparam logic [AW-1:0] HI = AW'(BASE_ADDR + WIN_SIZE);
  state_t state, next;
  logic [AW-1:0] addr;
  logic [DW-1:0] wd;
  logic [SW-1:0] be;
  logic aw_done, w_done, err, in_win, aw_hs, w_hs;
  assign in_win      = (data_addr >= LO) && (data_addr < HI);
  assign data_gnt    = data_req && (state == IDLE) && !rst;
  assign awvalid     = (state == WADDR) && !aw_done;
  assign wvalid      = (state == WADDR) && !w_done;
  assign aw_hs       = awvalid && awready;
  assign w_hs        = wvalid && wready;
  assign bready      = state == WRESP;
  assign arvalid     = state == RADDR;
  assign rready      = state == RDATA;
  assign data_rvalid = state == RESP;
  assign data_err    = data_rvalid && err;
  assign awaddr      = addr;
  assign araddr      = addr;
  assign wdata       = wd;
  assign wstrb       = be;
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= next;
  // next state: each AXI phase waits on its own handshake
  always_comb begin
    next = state;
    case (state)
      IDLE:    if (data_gnt) next = !in_win ? RESP : data_we ? WADDR : RADDR;
      WADDR:   if ((aw_done || aw_hs) && (w_done || w_hs)) next = WRESP;
      WRESP:   if (bvalid) next = RESP;
      RADDR:   if (arready) next = RDATA;
      RDATA:   if (rvalid) next = RESP;
      default: next = IDLE;
    endcase
  end
  // request latch, per-channel handshake tracking and response capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr       <= '0;
      wd         <= '0;
      be         <= '0;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
      err        <= 1'b0;
      data_rdata <= '0;
    end else begin
      if (data_gnt) begin
        addr    <= data_addr;
        wd      <= data_wdata;
        be      <= data_be;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end
      if (state == WADDR) begin
        aw_done <= aw_done || aw_hs;
        w_done  <= w_done || w_hs;
      end
      if (data_gnt && !in_win) begin
        err        <= 1'b1;
        data_rdata <= '0;
      end
      if (state == WRESP && bvalid) begin
        err        <= bresp >= 2'b10;
        data_rdata <= '0;
      end
      if (state == RDATA && rvalid) begin
        err        <= rresp >= 2'b10;
        data_rdata <= rdata;
      end
    end
  end
endmodule
